vga_fb_arbiter: RTL

Single-port framebuffer arbiter and pixel scheduler in front of the VGA timing core. It owns the one synchronous-read framebuffer RAM, which holds 160×120 pixels at 12 bits each. Each stored pixel is scaled ×4 in both directions onto the 640×480 raster. Video fetches take fixed time slots derived from the raster counters; a demo/CPU requester gets every remaining cycle. The block drives `pixstream` into the timing core and `frame_start` to the demo logic.

---
 rtl/vga_fb_arbiter_if.sv | 15 +
 rtl/vga_fb_arbiter.sv | 106 ++++++++++
 2 files changed

// File: rtl/vga_fb_arbiter_if.sv
// Requester-side bus of the framebuffer arbiter: request/ack handshake plus
// one 12-bit word of address/data per access.
interface vga_fb_arbiter_if #(
  parameter int ADDR_W = 15
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [11:0]       wdata;
  logic              ack;
  logic [11:0]       rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: fixed video fetch slots from the raster
// counters, a requester FSM on every remaining cycle, and the x4 pixel pipeline.
module vga_fb_arbiter #(
  parameter int H_START = 16,
  parameter int V_START = 10,
  parameter int ADDR_W  = 15
) (
  input  logic              clk_25_175,
  input  logic              reset,
  input  logic [9:0]        hcount,
  input  logic [9:0]        vcount,
  output logic [11:0]       pixstream,
  output logic              frame_start,
  vga_fb_arbiter_if.slave   req_bus,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [11:0]       mem_wdata,
  input  logic [11:0]       mem_rdata
);

  typedef enum logic {IDLE, ACK} state_t;

  state_t      state_q, state_d;
  logic [11:0] pix_hold_q, pix_hold_d;
  logic [11:0] rdata_q, rdata_d;
  logic        vis_q, vis_d;
  logic        load_q, load_d;
  logic        frame_start_q, frame_start_d;

  logic [10:0]       hoff;
  logic [10:0]       hnext;
  logic [7:0]        yblk;
  logic              v_act;
  logic              h_rng;
  logic              slot;
  logic              grant;
  logic [ADDR_W-1:0] vid_addr;

  // hoff is the fetch phase: a slot runs two cycles ahead of the pixels it feeds
  assign hoff     = {1'b0, hcount} + 11'd2 - 11'(H_START);
  assign hnext    = {1'b0, hcount} + 11'd1;
  assign yblk     = 8'((vcount - 10'(V_START)) >> 2);
  assign v_act    = (vcount >= 10'(V_START)) && (vcount <= 10'(V_START + 479));
  assign h_rng    = (hcount >= 10'(H_START - 2)) && (hcount <= 10'(H_START + 634));
  assign slot     = v_act && h_rng && (hoff[1:0] == 2'b00);
  assign vid_addr = ADDR_W'(yblk) * ADDR_W'(160) + ADDR_W'(hoff[10:2]);
  assign grant    = (state_q == IDLE) && req_bus.req && !slot;

  always_comb begin
    state_d       = IDLE;
    mem_addr      = '0;
    mem_we        = 1'b0;
    mem_wdata     = '0;
    load_d        = slot;
    pix_hold_d    = pix_hold_q;
    rdata_d       = rdata_q;
    // vis_d describes the next cycle so it lines up with the hold register load
    vis_d         = v_act && (hnext >= 11'(H_START)) && (hnext <= 11'(H_START + 639));
    frame_start_d = (vcount == 10'(V_START + 480)) && (hcount == 10'd0);

    if (grant) begin
      state_d = ACK;
    end

    if (slot) begin
      mem_addr = vid_addr;
    end else if (grant) begin
      mem_addr  = req_bus.addr;
      mem_we    = req_bus.we;
      mem_wdata = req_bus.wdata;
    end

    if (load_q) begin
      pix_hold_d = mem_rdata;
    end

    if ((state_q == ACK) && !req_bus.we) begin
      rdata_d = mem_rdata;
    end
  end

  always_ff @(posedge clk_25_175 or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      pix_hold_q    <= '0;
      rdata_q       <= '0;
      vis_q         <= 1'b0;
      load_q        <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pix_hold_q    <= pix_hold_d;
      rdata_q       <= rdata_d;
      vis_q         <= vis_d;
      load_q        <= load_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Read data is forwarded straight from the RAM during the ack cycle, then held
  assign req_bus.ack   = (state_q == ACK);
  assign req_bus.rdata = ((state_q == ACK) && !req_bus.we) ? mem_rdata : rdata_q;
  assign pixstream     = vis_q ? pix_hold_q : 12'h000;
  assign frame_start   = frame_start_q;

endmodule
